// File: rtl/rv32i_writeback_pipelined_pkg.sv
// Shared constants for the pipelined writeback stage: load encodings,
// FSM states and the datapath width legality check.
package rv32i_writeback_pipelined_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/rv32i_writeback_pipelined_load_extend.sv
// Load alignment and sign/zero extension; purely combinational.
module rv32i_load_extend
  import rv32i_writeback_pipelined_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_addr_lsb,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data_c
);

  logic [2:0]      offset;
  logic [XLEN-1:0] shifted;

  always_comb begin
    offset = (XLEN == 64) ? i_addr_lsb : {1'b0, i_addr_lsb[1:0]};
    // Offset bits below the access size are dropped; misalignment traps upstream.
    case (i_funct3)
      F3_LH, F3_LHU: offset[0]   = 1'b0;
      F3_LW, F3_LWU: offset[1:0] = 2'b00;
      F3_LD:         offset      = 3'd0;
      default: ;
    endcase
    shifted  = i_data >> {offset, 3'b000};
    o_data_c = '0;
    case (i_funct3)
      F3_LB:  o_data_c = XLEN'($signed(shifted[7:0]));
      F3_LH:  o_data_c = XLEN'($signed(shifted[15:0]));
      F3_LW:  o_data_c = XLEN'($signed(shifted[31:0]));
      F3_LD:  if (XLEN == 64) o_data_c = shifted;
      F3_LBU: o_data_c = XLEN'(shifted[7:0]);
      F3_LHU: o_data_c = XLEN'(shifted[15:0]);
      F3_LWU: if (XLEN == 64) o_data_c = XLEN'(shifted[31:0]);
      default: o_data_c = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback_pipelined.sv
// Registered writeback stage: destination value select, trap/mret redirect
// with a post-redirect flush window, and a retired-instruction counter.
module rv32i_writeback_pipelined
  import rv32i_writeback_pipelined_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_stall,
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_addr_lsb,
  input  logic [XLEN-1:0]   i_data_load,
  input  logic [XLEN-1:0]   i_csr_out,
  input  logic              i_opcode_load,
  input  logic              i_opcode_system,
  input  logic              i_wr_rd,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_rd,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_go_to_trap,
  input  logic              i_return_from_trap,
  input  logic [XLEN-1:0]   i_trap_address,
  input  logic [XLEN-1:0]   i_return_address,
  output logic              o_wr_rd,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_change_pc,
  output logic [XLEN-1:0]   o_next_pc,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_retire_count
);

  localparam int unsigned DCW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("rv32i_writeback_pipelined: XLEN must be 32 or 64");
  end

  logic [0:0]      state_q, state_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            flush_d;
  logic            accept, redirect, normal, retire;
  logic [XLEN-1:0] load_data, wb_data, target;
  logic            unused_pc;

  // PC is trace-only and never enters the datapath.
  assign unused_pc = ^i_pc;

  rv32i_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3   (i_funct3),
    .i_addr_lsb (i_addr_lsb),
    .i_data     (i_data_load),
    .o_data_c   (load_data)
  );

  assign o_ready  = (state_q == IDLE) && !i_stall;
  assign accept   = i_valid && o_ready;
  assign redirect = accept && (i_go_to_trap || i_return_from_trap);
  assign normal   = accept && !i_go_to_trap && !i_return_from_trap;
  assign retire   = accept && !i_go_to_trap;
  assign target   = i_go_to_trap ? i_trap_address : i_return_address;

  always_comb begin
    wb_data = i_rd;
    if (i_opcode_load)                               wb_data = load_data;
    else if (i_opcode_system && (i_funct3 != 3'b000)) wb_data = i_csr_out;
  end

  // Next state: the redirect cycle itself counts as the first DRAIN cycle.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    flush_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = DRAIN;
          drain_d = DCW'(FLUSH_CYCLES);
          flush_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q - DCW'(1);
          flush_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_rd        <= 1'b0;
      o_rd_addr      <= '0;
      o_rd           <= '0;
      o_change_pc    <= 1'b0;
      o_next_pc      <= '0;
      o_flush        <= 1'b0;
      o_retire_count <= '0;
    end else begin
      o_wr_rd     <= normal && i_wr_rd && (i_rd_addr != '0);
      o_change_pc <= redirect;
      o_flush     <= flush_d;
      if (accept) begin
        o_rd_addr <= i_rd_addr;
        o_rd      <= wb_data;
      end
      if (redirect) o_next_pc <= target;
      if (retire)   o_retire_count <= o_retire_count + CNT_W'(1);
    end
  end

endmodule
